// File: rtl/noc_pkg.sv
// Shared NoC link types: default flit width, flit type and sender FSM states.
package noc_pkg;

  localparam int FLIT_WIDTH_DEF = 16;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SIZE,
    PAYLOAD,
    DONE
  } sender_state_t;

endpackage

// File: rtl/noc_flit_out_reg.sv
// Output holding register for a credit-based link transmitter.
// A loaded flit stays on data_out with tx=1 until an edge where credit_i=1.
// ready flags that the register is empty or draining, so it can be loaded now.
module noc_flit_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             credit_i,
  output logic             tx,
  output logic [WIDTH-1:0] data_out,
  output logic             ready
);

  assign ready = ~tx | credit_i;

  // Load a new flit, otherwise drop tx once the held flit has been taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      tx       <= 1'b1;
      data_out <= load_data;
    end else if (credit_i) begin
      tx       <= 1'b0;
    end
  end

endmodule

// File: rtl/ni_packet_sender.sv
// Network-interface packet sender: emits header (target), size and payload
// flits into a router local port over a credit-based link.
// Optional build macro NI_SENDER_SRC_HDR_EN: the sender inserts its own
// ADDRESS as the first payload flit and reports req_size+1 (saturating).
module ni_packet_sender
  import noc_pkg::*;
#(
  parameter int                    FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter logic [FLIT_WIDTH-1:0] ADDRESS    = 'h0011
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FLIT_WIDTH-1:0] req_target,
  input  logic [FLIT_WIDTH-1:0] req_size,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [FLIT_WIDTH-1:0] pl_data,
  output logic                  clock_tx,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_out,
  input  logic                  credit_i,
  output logic                  busy,
  output logic                  pkt_sent
);

`ifdef NI_SENDER_SRC_HDR_EN
  localparam bit SRC_HDR = 1'b1;
`else
  localparam bit SRC_HDR = 1'b0;
`endif

  sender_state_t         state;
  logic [FLIT_WIDTH-1:0] count;
  logic                  load;
  logic [FLIT_WIDTH-1:0] load_data;
  logic                  out_ready;
  logic                  xfer;
  logic                  accept;
  logic                  pl_fire;

  // Size flit value when the sender adds its own source flit; never wraps.
  function automatic logic [FLIT_WIDTH-1:0] sat_inc(input logic [FLIT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign clock_tx  = clock;
  assign xfer      = tx & credit_i;
  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign pl_fire   = pl_valid & pl_ready;

  // Payload is pulled only when a flit slot is free this cycle; in SIZE the
  // first payload flit is pulled as the size flit leaves, so no bubble.
  always_comb begin
    pl_ready = 1'b0;
    case (state)
      SIZE:    pl_ready = !SRC_HDR && (count != '0) && xfer;
      PAYLOAD: pl_ready = (count != '0) && out_ready;
      default: pl_ready = 1'b0;
    endcase
  end

  // Select what enters the output register this cycle.
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    case (state)
      IDLE: begin
        load      = accept;
        load_data = req_target;
      end
      HDR: begin
        load      = xfer;
        load_data = SRC_HDR ? sat_inc(count) : count;
      end
      SIZE: begin
        if (SRC_HDR) begin
          load      = xfer;
          load_data = ADDRESS;
        end else begin
          load      = pl_fire;
          load_data = pl_data;
        end
      end
      PAYLOAD: begin
        load      = pl_fire;
        load_data = pl_data;
      end
      default: begin
        load      = 1'b0;
        load_data = '0;
      end
    endcase
  end

  // Packet sequencing; count holds the host payload flits still to accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      pkt_sent <= 1'b0;
    end else begin
      pkt_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count <= req_size;
            busy  <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (xfer) state <= SIZE;
        end
        SIZE: begin
          if (xfer) begin
            if (!SRC_HDR && (count == '0)) begin
              state    <= DONE;
              busy     <= 1'b0;
              pkt_sent <= 1'b1;
            end else begin
              state <= PAYLOAD;
            end
            if (pl_fire) count <= count - 1'b1;
          end
        end
        PAYLOAD: begin
          if (pl_fire) begin
            count <= count - 1'b1;
          end else if ((count == '0) && out_ready) begin
            state    <= DONE;
            busy     <= 1'b0;
            pkt_sent <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  noc_flit_out_reg #(
    .WIDTH(FLIT_WIDTH)
  ) u_out_reg (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .credit_i (credit_i),
    .tx       (tx),
    .data_out (data_out),
    .ready    (out_ready)
  );

endmodule

// File: tb/tb_ni_packet_sender.sv
// Testbench for ni_packet_sender: table of packet scenarios driven through a
// scoreboard of expected flits, plus hand-written reset sequences.
module tb_ni_packet_sender;

`ifdef NI_SENDER_SRC_HDR_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_target = '0;
  logic [15:0] req_size = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [15:0] pl_data = '0;
  logic        clock_tx;
  logic        tx;
  logic [15:0] data_out;
  logic        credit_i = 1'b1;
  logic        busy;
  logic        pkt_sent;

  always #5 clock = ~clock;

  ni_packet_sender dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_target(req_target),
    .req_size  (req_size),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .clock_tx  (clock_tx),
    .tx        (tx),
    .data_out  (data_out),
    .credit_i  (credit_i),
    .busy      (busy),
    .pkt_sent  (pkt_sent)
  );

  typedef struct {
    logic [15:0] target;
    int          size;
    logic [15:0] base;
    int          stall_at;
    int          stall_len;
    int          gap_at;
    int          gap_len;
    int          exp_lat;
    int          exp_tx;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one packet; inputs change on the falling edge, outputs are sampled 1ns later.
  task automatic run_pkt(input vec_t v);
    int          pay_idx = 0;
    int          xfers = 0;
    int          stall_done = 0;
    int          gap_done = 0;
    int          cyc = 0;
    int          txc = 0;
    bit          accepted = 0;
    bit          accept_now = 0;
    bit          done = 0;
    bit          prev_xfer = 0;
    bit          prev_stall = 0;
    logic [15:0] held = '0;
    logic [15:0] sz;
    sz = v.size[15:0];
    exp_q.push_back(v.target);
    if (EXTRA != 0) begin
      exp_q.push_back((sz == 16'hFFFF) ? sz : sz + 16'd1);
      exp_q.push_back(16'h0011);
    end else begin
      exp_q.push_back(sz);
    end
    for (int i = 0; i < v.size; i++) exp_q.push_back(v.base + 16'(i));
    @(negedge clock);
    req_valid  = 1'b1;
    req_target = v.target;
    req_size   = sz;
    while (!done && cyc < 300) begin
      if (accepted) begin
        req_valid = 1'b0;
        cyc++;
      end
      credit_i = !(tx && xfers == v.stall_at && stall_done < v.stall_len);
      if (!credit_i) stall_done++;
      if (pay_idx < v.size && pay_idx == v.gap_at && gap_done < v.gap_len) begin
        pl_valid = 1'b0;
        gap_done++;
      end else if (pay_idx < v.size) begin
        pl_valid = 1'b1;
        pl_data  = v.base + 16'(pay_idx);
      end else begin
        pl_valid = 1'b0;
      end
      #1;
      if (accepted) begin
        if (pkt_sent) begin
          check("pkt_sent_after_last", 32'({prev_xfer, exp_q.size() == 0}), 32'h3);
          check("busy_in_done", 32'(busy), 32'h0);
          done = 1;
        end else begin
          check("busy_during_pkt", 32'(busy), 32'h1);
        end
        if (tx) txc++;
      end else begin
        check("pkt_sent_idle", 32'(pkt_sent), 32'h0);
      end
      if (prev_stall) begin
        check("stall_hold_tx", 32'(tx), 32'h1);
        check("stall_hold_data", 32'(data_out), 32'(held));
      end
      prev_stall = tx && !credit_i;
      held       = data_out;
      check("pl_ready_no_payload", 32'(pl_ready && pay_idx >= v.size), 32'h0);
      prev_xfer = tx && credit_i;
      if (tx && credit_i) begin
        xfers++;
        if (exp_q.size() == 0) check("extra_flit", 32'(data_out), 32'hFFFFFFFF);
        else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (pl_valid && pl_ready) pay_idx++;
      accept_now = req_valid && req_ready;
      @(posedge clock);
      if (accept_now) accepted = 1;
      if (!done) @(negedge clock);
    end
    check("pkt_completed", 32'(done), 32'h1);
    check("latency", 32'(cyc), 32'(v.exp_lat + EXTRA));
    check("tx_cycles", 32'(txc), 32'(v.exp_tx + EXTRA));
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("payload_consumed", 32'(pay_idx), 32'(v.size));
    exp_q.delete();
    pl_valid = 1'b0;
    credit_i = 1'b1;
  endtask

  initial begin
    //          target    size base     st_at len gap_at len lat tx
    vecs[0] = '{16'h0022, 3, 16'h00A1, -1, 0, -1, 0,  6, 5};
    vecs[1] = '{16'h0022, 3, 16'h00A1,  1, 4, -1, 0, 10, 9};
    vecs[2] = '{16'h0022, 0, 16'h00A1, -1, 0, -1, 0,  3, 2};
    vecs[3] = '{16'h0022, 3, 16'h00A1, -1, 0,  1, 2,  8, 5};
    vecs[4] = '{16'h0022, 2, 16'h00A1, -1, 0, -1, 0,  5, 4};

    #1 reset = 1'b0;
    #1;
    check("reset_tx", 32'(tx), 32'h0);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_pkt_sent", 32'(pkt_sent), 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check("idle_tx", 32'(tx), 32'h0);
      check("idle_req_ready", 32'(req_ready), 32'h1);
      check("idle_busy", 32'(busy), 32'h0);
    end

    for (int i = 0; i < 5; i++) run_pkt(vecs[i]);

    // Abort a packet by reset right after its header flit is taken.
    @(negedge clock);
    req_valid  = 1'b1;
    req_target = 16'h0022;
    req_size   = 16'd3;
    credit_i   = 1'b1;
    pl_valid   = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    check("abort_hdr_tx", 32'(tx), 32'h1);
    check("abort_hdr_data", 32'(data_out), 32'h0022);
    @(posedge clock);
    #1;
    check("abort_size_presented", 32'(data_out), 32'h0003);
    #2 reset = 1'b0;
    #1;
    check("abort_tx_async", 32'(tx), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data_out", 32'(data_out), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    run_pkt('{16'h0033, 1, 16'h00B1, -1, 0, -1, 0, 4, 3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_packet_sender.md
Name: ni_packet_sender

Overview:
- Network-interface transmitter that injects packets into a router's local input port.
- It is the sending end of the credit-based link whose receiving end is the router input (rx / data_in / credit_o).
- Takes a packet request (target address, payload length) plus a payload flit stream from the host side and emits header, size and payload flits.
- A flit transfers on any clock edge where tx=1 and credit_i=1.

Parameters:
- FLIT_WIDTH, 16, width of a flit and of data_out.
- ADDRESS, 16'h0011, this node's router address; used only by the optional feature.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  packet request present.
- req_ready  out  1  sender idle, request accepted when req_valid & req_ready.
- req_target  in  FLIT_WIDTH  destination router address (header flit).
- req_size  in  FLIT_WIDTH  payload flit count, 0 allowed.
- pl_valid  in  1  payload flit present.
- pl_ready  out  1  payload flit accepted when pl_valid & pl_ready.
- pl_data  in  FLIT_WIDTH  payload flit.
- clock_tx  out  1  equals clock.
- tx  out  1  data_out holds a valid flit.
- data_out  out  FLIT_WIDTH  flit to router.
- credit_i  in  1  router can accept a flit this cycle.
- busy  out  1  packet in progress.
- pkt_sent  out  1  one-cycle pulse after the last flit transfers.

Behaviour:
- Reset values:
  - tx=0, data_out=0, busy=0, pkt_sent=0.
  - State IDLE, counter=0.
  - req_ready=1 once reset deasserts.
- Reset asserted mid-packet aborts the packet immediately. No partial recovery; the router side is reset together.
- tx and data_out are registered. A presented flit holds stable, with tx=1, until the edge where credit_i=1.
- FSM states and transitions:
  - IDLE: req_ready=1.
    - On acceptance at edge N: latch target and size, go to HDR.
    - At N+1: tx=1, data_out=target.
  - HDR: on transfer, present the size flit next cycle and go to SIZE.
  - SIZE:
    - On transfer with size=0: go to DONE.
    - On transfer otherwise: go to PAYLOAD, remaining=size.
  - PAYLOAD:
    - pl_ready=1 when (tx=0) or (tx=1 & credit_i=1), i.e. the output register is empty or draining this cycle.
    - An accepted payload flit loads data_out; remaining decrements on acceptance.
    - After the flit with remaining=1 is accepted, pl_ready=0.
    - After that last flit transfers, go to DONE.
    - If pl_valid=0 while the register drains: tx=0 (bubble); credit is not consumed.
  - DONE: pkt_sent=1 for one cycle, busy=0, return to IDLE. The next request can be accepted the following cycle.
- Throughput:
  - One flit per cycle while credit_i=1 and the payload is valid (no bubbles between header, size and payload).
  - Packet of S payload flits with no stalls: tx high for S+2 consecutive cycles.
- credit_i dropping while tx=1: hold the flit indefinitely; no timeout.
- busy=1 from the acceptance cycle+1 through the last transfer.
- req_size arithmetic is unsigned FLIT_WIDTH. Maximum 2^FLIT_WIDTH-1 flits; no wrap (the counter only decrements to 0).
- req_valid while busy is ignored (req_ready=0).

Optional Feature:
- Macro: NI_SENDER_SRC_HDR_EN.
- When defined:
  - The first payload flit is ADDRESS, inserted by the sender.
  - The emitted size flit equals req_size+1, saturating at all-ones.
  - The host still supplies req_size flits.
  - pl_ready=0 during the inserted flit.
- When undefined: the packet is exactly header, req_size, host payload.

Decomposition:
- Package noc_pkg:
  - FLIT_WIDTH default constant.
  - flit_t typedef.
  - sender_state_t enum {IDLE, HDR, SIZE, PAYLOAD, DONE}.
- One natural sub-module: noc_flit_out_reg, the holding register for tx/data_out with a load/hold/drain rule, reusable by other link transmitters.

Test Plan:
- Reset release with credit_i=1, no request -> tx=0, req_ready=1, busy=0 for 10 cycles.
- req target=16'h0022, size=3, payload A1,A2,A3 always valid, credit_i=1 -> data_out 0022,0003,A1,A2,A3 on 5 consecutive cycles; pkt_sent pulses 1 cycle after A3.
- Same packet with credit_i=0 for 4 cycles while the size flit is presented -> data_out=0003 held with tx=1 for 5 cycles, then the stream resumes unchanged.
- size=0 -> exactly 2 flits (target, 0000); pl_ready never 1; pkt_sent follows.
- Payload gap (pl_valid low 2 cycles after A1) -> tx=0 for those cycles; no flit duplicated; A2,A3 follow.
- reset asserted after the header transfers, then a new request target=0033 size=1 -> tx drops to 0 asynchronously; new packet 0033,0001,B1 correct.
- (NI_SENDER_SRC_HDR_EN) size=2 -> 0022,0003,0011,A1,A2.
